minmax_frame_sel: RTL and testbench
===================================

Name: minmax_frame_sel

Overview:
- Sequential, streaming successor to the 4-input combinational min/max selector.
- Accepts a frame of FRAME_LEN samples over a valid/ready input handshake and tracks the running extremum (max or min, chosen per frame).
- Presents the result, optionally with the winning sample's index, on a valid/ready output handshake.
- Used wherever the team needs the min/max over more than a fixed handful of operands without a wide comparator tree.

Parameters:
WIDTH, 8, sample and result width in bits; unsigned compare.
FRAME_LEN, 4, samples per frame; legal range 2..256.
IDX_W, $clog2(FRAME_LEN), width of the sample counter and index.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
clr  input  1  synchronous abort: discard the current frame or pending result.
mode_max  input  1  1 = maximum, 0 = minimum; sampled with the first sample of each frame.
in_data  input  WIDTH  sample.
in_valid  input  1  sample present.
in_ready  output  1  block can accept a sample.
out_data  output  WIDTH  frame extremum.
out_valid  output  1  result present.
out_ready  input  1  consumer accepts the result.
out_idx  output  IDX_W  position of the extremum in the frame; present only with MINMAX_INDEX_EN.

Behaviour:
- Reset (rst_n low, asynchronous): state=ACCUM, count=0, in_ready=1, out_valid=0, out_data=0, out_idx=0, latched mode=1.
- A transfer occurs in a cycle where valid and ready are both high; there is no combinational path from in_valid to in_ready.
- FSM has two states: ACCUM and OUT.
- ACCUM state:
  - in_ready=1, out_valid=0.
  - On an accepted sample with count==0: load acc=in_data, idx=0, latch mode=mode_max.
  - On an accepted sample with count>0: replace acc/idx only if in_data is strictly greater (mode 1) or strictly less (mode 0) than acc. Ties keep the earliest index.
  - count increments on each accepted sample.
  - When the accepted sample has count==FRAME_LEN-1: count wraps to 0 and the state moves to OUT.
- OUT state:
  - in_ready=0, out_valid=1.
  - out_data and out_idx are held stable while out_ready is low.
  - On out_ready: return to ACCUM next cycle, with in_ready=1 that cycle.
- Latency: out_valid rises the cycle after the last sample is accepted. Minimum frame period is FRAME_LEN+1 cycles. Input and output do not overlap.
- mode_max changes mid-frame are ignored until the next frame's first sample.
- Boundaries:
  - All-equal frame: out_data is that value, out_idx=0.
  - Values 0 and 2^WIDTH-1 compare correctly; there is no overflow path.
- clr: takes priority over the handshake. Next cycle state=ACCUM, count=0, out_valid=0; out_data and out_idx are held at their last value.
- Reset mid-frame: partial frame is discarded; the next FRAME_LEN accepted samples form a fresh frame.
- in_valid with in_ready low: no effect; the sample is not consumed.

Optional Feature:
- MINMAX_INDEX_EN defined:
  - out_idx port exists and the index register is built.
  - out_idx reports the position (0..FRAME_LEN-1) of the first occurrence of the extremum.
  - out_idx is valid with out_valid.
- MINMAX_INDEX_EN undefined:
  - No out_idx port and no index logic.
  - All other behaviour is identical.

Test Plan:
- Reset, then idle -> in_ready=1, out_valid=0, out_data=0, out_idx=0. rst_n pulsed low mid-run -> outputs return to these values immediately, without waiting for a clock edge.
- mode_max=1, samples 3,9,9,1 back-to-back -> out_valid rises one cycle after the 4th sample is accepted, with out_data=9, out_idx=1; in_ready=0 while out_valid=1.
- mode_max=0, samples 7,2,5,2 -> out_data=2, out_idx=1. Then samples 0,255,255,0 with mode_max=1 -> out_data=255, out_idx=1.
- mode_max=1 on the first sample, then 0 for the rest; samples 4,8,1,6 -> out_data=8 (max kept).
- Backpressure: out_ready=0 for 5 cycles after the result -> out_valid=1 and out_data stable throughout. out_ready=1 -> next cycle in_ready=1, and the next frame 10,20,30,40 gives 40, idx 3.
- Abort: after 2 samples (50,60), assert clr for 1 cycle -> count=0. Then samples 1,2,3,4 (max) -> out_data=4, not 60. Repeat with rst_n low after 2 samples -> same result.

Source files
------------

// File: rtl/minmax_frame_sel.sv
// minmax_frame_sel: streaming per-frame min/max selector with valid/ready handshakes
// Optional feature macro: MINMAX_INDEX_EN (builds the index register and out_idx port)
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   clr                 synchronous abort of the current frame or pending result
//   mode_max            1 = maximum, 0 = minimum, sampled with each frame's first sample
//   in_data/in_valid/in_ready     sample input handshake
//   out_data/out_valid/out_ready  result output handshake
//   out_idx             position of the first occurrence of the extremum (MINMAX_INDEX_EN only)
module minmax_frame_sel #(
    parameter int WIDTH     = 8,
    parameter int FRAME_LEN = 4,
    parameter int IDX_W     = $clog2(FRAME_LEN)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             mode_max,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
`ifdef MINMAX_INDEX_EN
    ,
    output logic [IDX_W-1:0] out_idx
`endif
);
    localparam logic [0:0] ACCUM = 1'b0;
    localparam logic [0:0] OUT   = 1'b1;
    logic [0:0]       state;
    logic [IDX_W-1:0] count;
    logic [WIDTH-1:0] acc;
    logic             mode;
    logic             take, first, last, better;
    assign take      = in_valid && state == ACCUM;
    assign first     = count == '0;
    assign last      = count == IDX_W'(FRAME_LEN - 1);
    // strict compare so ties keep the earliest sample
    assign better    = mode ? in_data > acc : in_data < acc;
    assign in_ready  = state == ACCUM;
    assign out_valid = state == OUT;
    assign out_data  = acc;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ACCUM;
            count <= '0;
            acc   <= '0;
            mode  <= 1'b1;
        end else if (clr) begin
            state <= ACCUM;
            count <= '0;
        end else if (take) begin
            if (first || better) acc <= in_data;
            if (first) mode <= mode_max;
            count <= last ? '0 : count + IDX_W'(1);
            if (last) state <= OUT;
        end else if (state == OUT && out_ready) begin
            state <= ACCUM;
        end
    end
`ifdef MINMAX_INDEX_EN
    logic [IDX_W-1:0] idx;
    assign out_idx = idx;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) idx <= '0;
        else if (!clr && take && (first || better)) idx <= count;
    end
`endif
endmodule

// File: tb/tb_minmax_frame_sel.sv
// tb_minmax_frame_sel: scoreboard bench for minmax_frame_sel
module tb_minmax_frame_sel;
    typedef logic [7:0] frame_t [4];
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr = 1'b0;
    logic       mode_max = 1'b1;
    logic [7:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b0;
`ifdef MINMAX_INDEX_EN
    logic [1:0] out_idx;
`endif
    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q[$];
    logic [1:0] expi_q[$];

    minmax_frame_sel #(.WIDTH(8), .FRAME_LEN(4)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .mode_max(mode_max),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid),
`ifdef MINMAX_INDEX_EN
        .out_idx(out_idx),
`endif
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    // Reference: first occurrence of the extremum under the frame's first mode.
    task automatic model(input frame_t f, input logic m, output logic [7:0] d, output logic [1:0] ix);
        d = f[0];
        ix = 0;
        for (int i = 1; i < 4; i++)
            if ((m && f[i] > d) || (!m && f[i] < d)) begin
                d = f[i];
                ix = 2'(i);
            end
    endtask

    // Drives n samples starting at a negedge; returns on the negedge after the last accept.
    task automatic send_frame(input frame_t f, input int n, input logic m0, input logic mr, input bit push);
        logic [7:0] d;
        logic [1:0] ix;
        if (push) begin
            model(f, m0, d, ix);
            exp_q.push_back(d);
            expi_q.push_back(ix);
        end
        for (int i = 0; i < n; i++) begin
            int t = 0;
            while (!in_ready && t < 50) begin
                @(negedge clk);
                t++;
            end
            if (!in_ready) begin
                checks++;
                errors++;
                $display("FAIL in_ready_timeout: got in_ready=%0b expected 1", in_ready);
            end
            in_valid = 1'b1;
            in_data = f[i];
            mode_max = (i == 0) ? m0 : mr;
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic get_result(output logic [7:0] d, output logic [1:0] ix, output bit ok);
        int t = 0;
        out_ready = 1'b1;
        while (!out_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        ok = out_valid;
        d = out_data;
        ix = 0;
`ifdef MINMAX_INDEX_EN
        ix = out_idx;
`endif
        if (ok) @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b expected 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
        checks++; if (out_data !== 8'd0) begin errors++; $display("FAIL reset_out_data: got %0d expected 0", out_data); end
`ifdef MINMAX_INDEX_EN
        checks++; if (out_idx !== 2'd0) begin errors++; $display("FAIL reset_out_idx: got %0d expected 0", out_idx); end
`endif
    endtask

    task automatic test_frame(input string name, input frame_t f, input logic m0, input logic mr);
        logic [7:0] d, ed;
        logic [1:0] ix, ei;
        bit ok;
        send_frame(f, 4, m0, mr, 1);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL %s_latency: got out_valid=%0b expected 1", name, out_valid); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL %s_in_ready_out: got %0b expected 0", name, in_ready); end
        get_result(d, ix, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s_timeout: got out_valid=0 expected 1", name);
        end else begin
            ed = exp_q.pop_front();
            ei = expi_q.pop_front();
            if (d !== ed) begin errors++; $display("FAIL %s_data: got %0d expected %0d", name, d, ed); end
`ifdef MINMAX_INDEX_EN
            checks++; if (ix !== ei) begin errors++; $display("FAIL %s_idx: got %0d expected %0d", name, ix, ei); end
`endif
        end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL %s_ready_after: got %0b expected 1", name, in_ready); end
    endtask

    task automatic test_max;
        frame_t f;
        f = '{8'd3, 8'd9, 8'd9, 8'd1};
        test_frame("max", f, 1'b1, 1'b1);
    endtask

    task automatic test_min;
        frame_t f;
        f = '{8'd7, 8'd2, 8'd5, 8'd2};
        test_frame("min", f, 1'b0, 1'b0);
        f = '{8'd0, 8'd255, 8'd255, 8'd0};
        test_frame("extremes", f, 1'b1, 1'b1);
        f = '{8'd5, 8'd5, 8'd5, 8'd5};
        test_frame("all_equal", f, 1'b0, 1'b0);
    endtask

    task automatic test_mode_latch;
        frame_t f;
        f = '{8'd4, 8'd8, 8'd1, 8'd6};
        test_frame("mode_latch", f, 1'b1, 1'b0);
    endtask

    task automatic test_backpressure;
        frame_t f;
        logic [7:0] ed;
        f = '{8'd5, 8'd6, 8'd7, 8'd8};
        send_frame(f, 4, 1'b1, 1'b1, 1);
        in_valid = 1'b1;
        in_data = 8'd99;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_%0d: got %0b expected 1", i, out_valid); end
            checks++; if (out_data !== exp_q[0]) begin errors++; $display("FAIL bp_data_%0d: got %0d expected %0d", i, out_data, exp_q[0]); end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        ed = exp_q.pop_front();
        void'(expi_q.pop_front());
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %0b expected 1 (result %0d)", in_ready, ed); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid: got %0b expected 0", out_valid); end
        f = '{8'd10, 8'd20, 8'd30, 8'd40};
        test_frame("bp_next", f, 1'b1, 1'b1);
    endtask

    task automatic test_abort;
        frame_t f;
        f = '{8'd50, 8'd60, 8'd0, 8'd0};
        send_frame(f, 2, 1'b1, 1'b1, 0);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL clr_valid: got %0b expected 0", out_valid); end
        f = '{8'd1, 8'd2, 8'd3, 8'd4};
        test_frame("after_clr", f, 1'b1, 1'b1);
    endtask

    task automatic test_reset_mid;
        frame_t f;
        f = '{8'd9, 8'd8, 8'd7, 8'd6};
        send_frame(f, 4, 1'b1, 1'b1, 0);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL arst_in_ready: got %0b expected 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_out_valid: got %0b expected 0", out_valid); end
        checks++; if (out_data !== 8'd0) begin errors++; $display("FAIL arst_out_data: got %0d expected 0", out_data); end
`ifdef MINMAX_INDEX_EN
        checks++; if (out_idx !== 2'd0) begin errors++; $display("FAIL arst_out_idx: got %0d expected 0", out_idx); end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        f = '{8'd50, 8'd60, 8'd0, 8'd0};
        send_frame(f, 2, 1'b1, 1'b1, 0);
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        f = '{8'd1, 8'd2, 8'd3, 8'd4};
        test_frame("after_rst", f, 1'b1, 1'b1);
    endtask

    initial begin
        test_reset;
        test_max;
        test_min;
        test_mode_latch;
        test_backpressure;
        test_abort;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
